// File: rtl/fir_ctrl_pkg.sv
// Shared types and helpers for the FIR data-RAM sequencer.
package fir_ctrl_pkg;

  typedef enum logic [1:0] {
    StInit,
    StReady,
    StRun
  } state_e;

  localparam int unsigned NTapDefault = 12;
  localparam int unsigned ByteShift   = 2;
  localparam int unsigned IdxW        = 4;

  // Word index to byte address; callers truncate to their address width.
  function automatic logic [31:0] word_to_byte(input logic [IdxW-1:0] idx);
    return {28'b0, idx} << ByteShift;
  endfunction

endpackage

// File: rtl/mod_ptr.sv
// Modulo-N up/down pointer with clear and load; clear beats load beats inc beats dec.
module mod_ptr #(
  parameter int unsigned N = 12,
  parameter int unsigned W = 4
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] ptr
);

  logic [W-1:0] ptr_q, ptr_d;

  // Next pointer value, wrapping at N rather than at 2**W.
  always_comb begin
    ptr_d = ptr_q;
    if (clr) begin
      ptr_d = '0;
    end else if (load) begin
      ptr_d = load_val;
    end else if (inc) begin
      ptr_d = (ptr_q == W'(N - 1)) ? '0 : ptr_q + 1'b1;
    end else if (dec) begin
      ptr_d = (ptr_q == '0) ? W'(N - 1) : ptr_q - 1'b1;
    end
  end

  // Pointer register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/fir_data_ram_ctrl.sv
// FIR data-sample buffer sequencer: zero-fills the RAM, writes each accepted sample over
// the oldest entry, then streams all taps newest-first with the matching coefficient address.
module fir_data_ram_ctrl
  import fir_ctrl_pkg::*;
#(
  parameter int unsigned N_TAP = NTapDefault,
  parameter int unsigned AW    = 12,
  parameter int unsigned DW    = 32
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          d_EN,
  output logic [3:0]    d_WE,
  output logic [AW-1:0] d_A,
  output logic [DW-1:0] d_Di,
  input  logic [DW-1:0] d_Do,
  output logic [AW-1:0] tap_A,
  output logic          mac_valid,
  output logic [DW-1:0] mac_data,
  output logic [3:0]    mac_tap_idx,
  output logic          mac_last
);

  state_e state_q, state_d;
  logic [IdxW-1:0] k_q, k_d;
  logic [IdxW-1:0] head, rd_idx;
  logic head_clr, head_inc, rd_load, rd_dec;
  logic k_last;

  logic          rdy, issue;
  logic [3:0]    we;
  logic [AW-1:0] a, ta;
  logic [DW-1:0] di;

  logic          mac_valid_q, mac_last_q;
  logic [3:0]    mac_idx_q;

  assign k_last = (k_q == IdxW'(N_TAP - 1));

  // Oldest-entry pointer: advances once per completed burst.
  mod_ptr #(
    .N(N_TAP),
    .W(IdxW)
  ) u_head (
    .CLK     (CLK),
    .RST     (RST),
    .clr     (head_clr),
    .load    (1'b0),
    .load_val('0),
    .inc     (head_inc),
    .dec     (1'b0),
    .ptr     (head)
  );

  // Read index: loaded with head at the handshake, walks backwards through the taps.
  mod_ptr #(
    .N(N_TAP),
    .W(IdxW)
  ) u_rd (
    .CLK     (CLK),
    .RST     (RST),
    .clr     (1'b0),
    .load    (rd_load),
    .load_val(head),
    .inc     (1'b0),
    .dec     (rd_dec),
    .ptr     (rd_idx)
  );

  // Next-state, counter and RAM-port decode.
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    head_clr = 1'b0;
    head_inc = 1'b0;
    rd_load  = 1'b0;
    rd_dec   = 1'b0;
    rdy      = 1'b0;
    issue    = 1'b0;
    we       = 4'h0;
    a        = '0;
    di       = '0;
    ta       = '0;
    case (state_q)
      StInit: begin
        we = 4'hF;
        a  = AW'(word_to_byte(k_q));
        if (k_last) begin
          k_d     = '0;
          state_d = StReady;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      StReady: begin
        rdy = 1'b1;
        // A sample takes priority over a simultaneous start.
        if (in_valid) begin
          we      = 4'hF;
          a       = AW'(word_to_byte(head));
          di      = in_data;
          rd_load = 1'b1;
          k_d     = '0;
          state_d = StRun;
        end else if (start) begin
          head_clr = 1'b1;
          k_d      = '0;
          state_d  = StInit;
        end
      end
      StRun: begin
        issue  = 1'b1;
        rd_dec = 1'b1;
        a      = AW'(word_to_byte(rd_idx));
        ta     = AW'(word_to_byte(k_q));
        if (k_last) begin
          head_inc = 1'b1;
          k_d      = '0;
          state_d  = StReady;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      default: begin
        k_d     = '0;
        state_d = StInit;
      end
    endcase
  end

  // State and tap counter registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= StInit;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
    end
  end

  // Read-issue qualifiers delayed to line up with the RAM's registered read data.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mac_valid_q <= 1'b0;
      mac_idx_q   <= '0;
      mac_last_q  <= 1'b0;
    end else begin
      mac_valid_q <= issue;
      mac_idx_q   <= k_q;
      mac_last_q  <= issue & k_last;
    end
  end

  // Combinational outputs are forced low for as long as reset is held.
  assign in_ready    = ~RST & rdy;
  assign d_EN        = ~RST;
  assign d_WE        = RST ? 4'h0 : we;
  assign d_A         = RST ? '0 : a;
  assign d_Di        = RST ? '0 : di;
  assign tap_A       = RST ? '0 : ta;
  assign mac_data    = RST ? '0 : d_Do;
  assign mac_valid   = mac_valid_q;
  assign mac_tap_idx = mac_idx_q;
  assign mac_last    = mac_last_q;

endmodule

// File: tb/tb_fir_data_ram_ctrl.sv
// Self-checking bench for fir_data_ram_ctrl with a behavioural RAM and a sample-history model.
module tb_fir_data_ram_ctrl;

  localparam int N = 12;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  idx;
    logic        last;
  } beat_t;

  logic        CLK = 1'b0;
  logic        RST;
  logic        start;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        d_EN;
  logic [3:0]  d_WE;
  logic [11:0] d_A;
  logic [31:0] d_Di;
  logic [31:0] d_Do;
  logic [11:0] tap_A;
  logic        mac_valid;
  logic [31:0] mac_data;
  logic [3:0]  mac_tap_idx;
  logic        mac_last;

  int n_checks = 0;
  int n_errors = 0;
  int cycle = 0;

  // Reference model: sample history newest-first, plus the expected oldest-entry slot.
  logic [31:0] m_hist[$];
  int          m_head;
  beat_t       exp_q[$];
  int          last_hs;
  int          exp_gap;

  // RAM model: 12 words, registered read address, read data gated by EN.
  logic [31:0] mem [N];
  logic [3:0]  raddr_q = 4'd0;
  logic        scrub;

  logic any_out;
  assign any_out = |{d_EN, d_WE, d_A, d_Di, tap_A, in_ready, mac_valid, mac_data,
                     mac_tap_idx, mac_last};

  fir_data_ram_ctrl #(
    .N_TAP(N),
    .AW   (12),
    .DW   (32)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .start      (start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .d_EN       (d_EN),
    .d_WE       (d_WE),
    .d_A        (d_A),
    .d_Di       (d_Di),
    .d_Do       (d_Do),
    .tap_A      (tap_A),
    .mac_valid  (mac_valid),
    .mac_data   (mac_data),
    .mac_tap_idx(mac_tap_idx),
    .mac_last   (mac_last)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cycle <= cycle + 1;

  always @(posedge CLK) begin
    if (scrub) begin
      for (int i = 0; i < N; i++) mem[i] <= $urandom | 32'h1;
    end else if (d_EN) begin
      for (int b = 0; b < 4; b++) begin
        if (d_WE[b] && d_A[5:2] < 4'd12) mem[d_A[5:2]][8*b +: 8] <= d_Di[8*b +: 8];
      end
      raddr_q <= d_A[5:2];
    end
  end

  assign d_Do = (d_EN && raddr_q < 4'd12) ? mem[raddr_q] : 32'h0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cycle);
    end
  endtask

  task automatic model_clear();
    m_hist.delete();
    for (int i = 0; i < N; i++) m_hist.push_back(32'h0);
    m_head = 0;
  endtask

  // Beat scoreboard.
  initial begin
    beat_t b;
    forever begin
      @(negedge CLK);
      if (!RST && mac_valid) begin
        if (exp_q.size() == 0) begin
          check("beat_unexpected", 32'(mac_valid), 32'h0);
        end else begin
          b = exp_q.pop_front();
          check("mac_data", mac_data, b.data);
          check("mac_tap_idx", 32'(mac_tap_idx), 32'(b.idx));
          check("mac_last", 32'(mac_last), 32'(b.last));
        end
      end
    end
  end

  // Expects the zero-fill sweep starting in the current cycle; ends one cycle into READY.
  task automatic init_check();
    for (int i = 0; i < N; i++) begin
      @(negedge CLK);
      check("init_rdy", 32'(in_ready), 32'h0);
      check("init_we", 32'(d_WE), 32'hF);
      check("init_a", 32'(d_A), 4 * i);
      check("init_di", d_Di, 32'h0);
      @(posedge CLK); #1;
    end
    @(negedge CLK);
    check("init_done_rdy", 32'(in_ready), 32'h1);
    for (int i = 0; i < N; i++) check("init_zero", mem[i], 32'h0);
    @(posedge CLK); #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge CLK);
    check("start_rdy", 32'(in_ready), 32'h1);
    check("start_we", 32'(d_WE), 32'h0);
    @(posedge CLK); #1;
    start = 1'b0;
    model_clear();
    init_check();
  endtask

  // Offer v, check the write and the read sweep; optionally hold the next sample and pulse
  // start during RUN, or assert reset at read abort_k.
  task automatic send_sample(input logic [31:0] v, input bit stall, input logic [31:0] nv,
                             input int abort_k);
    bit got = 1'b0;
    in_valid = 1'b1;
    in_data  = v;
    for (int t = 0; t < 64; t++) begin
      @(negedge CLK);
      if (in_ready) begin
        got = 1'b1;
        break;
      end
      @(posedge CLK); #1;
    end
    if (!got) begin
      check("hs_timeout", 32'h0, 32'h1);
      in_valid = 1'b0;
      return;
    end
    check("hs_we", 32'(d_WE), 32'hF);
    check("hs_a", 32'(d_A), 4 * m_head);
    check("hs_di", d_Di, v);
    if (exp_gap != 0) check("hs_gap", cycle - last_hs, exp_gap);
    last_hs = cycle;
    m_hist.push_front(v);
    void'(m_hist.pop_back());
    for (int k = 0; k < N; k++) exp_q.push_back('{data: m_hist[k], idx: 4'(k), last: k == N - 1});
    @(posedge CLK); #1;
    in_valid = stall;
    in_data  = stall ? nv : 32'h0;
    for (int k = 0; k < N; k++) begin
      start = stall && (k == 3);
      if (k == abort_k) begin
        RST = 1'b1;
        start = 1'b0;
        in_valid = 1'b0;
        #1;
        check("rst_outs_run", 32'(any_out), 32'h0);
        exp_q.delete();
        repeat (3) begin
          @(negedge CLK);
          check("rst_mac_valid", 32'(mac_valid), 32'h0);
        end
        @(posedge CLK); #1;
        RST = 1'b0;
        model_clear();
        init_check();
        return;
      end
      @(negedge CLK);
      check("run_we", 32'(d_WE), 32'h0);
      check("run_rdy", 32'(in_ready), 32'h0);
      check("run_en", 32'(d_EN), 32'h1);
      check("run_a", 32'(d_A), 4 * ((m_head - k + N) % N));
      check("run_tap", 32'(tap_A), 4 * k);
      @(posedge CLK); #1;
    end
    start  = 1'b0;
    m_head = (m_head + 1) % N;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int gap;
    RST      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 32'h0;
    scrub    = 1'b1;
    exp_gap  = 0;
    last_hs  = 0;
    @(posedge CLK); #1;
    scrub = 1'b0;
    @(negedge CLK);
    check("rst_outs", 32'(any_out), 32'h0);
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    model_clear();
    init_check();

    // First sample.
    send_sample(32'd5, 1'b0, 32'h0, -1);

    // Back-to-back wrap from a cleared buffer.
    do_start();
    for (int i = 1; i <= 14; i++) begin
      exp_gap = (i == 1) ? 0 : 13;
      send_sample(32'(i), 1'b0, 32'h0, -1);
    end
    exp_gap = 0;

    // Start after three samples, then a lone sample.
    for (int i = 0; i < 3; i++) send_sample($urandom, 1'b0, 32'h0, -1);
    do_start();
    send_sample(32'd9, 1'b0, 32'h0, -1);

    // Start and a held sample during RUN.
    send_sample(32'hA5A5_0001, 1'b1, 32'hA5A5_0002, -1);
    exp_gap = 13;
    send_sample(32'hA5A5_0002, 1'b0, 32'h0, -1);
    exp_gap = 0;

    // Randomized traffic with idle gaps and occasional start alongside a sample.
    for (int i = 0; i < 16; i++) begin
      gap = $urandom_range(0, 3);
      repeat (gap) begin
        @(posedge CLK); #1;
      end
      exp_gap = 13 + gap;
      start   = ($urandom_range(0, 3) == 0);
      send_sample($urandom, 1'b0, 32'h0, -1);
    end
    exp_gap = 0;

    // Reset at the fifth read, then resume from a clean buffer.
    send_sample(32'hDEAD_BEEF, 1'b0, 32'h0, 4);
    send_sample(32'h1234_5678, 1'b0, 32'h0, -1);
    send_sample($urandom, 1'b0, 32'h0, -1);

    repeat (3) @(posedge CLK);
    #1;
    check("beats_left", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
